// File: rtl/cmos_frame_capture.sv
// OV7670-style byte stream to RGB565 pixel writer for the frame buffer.
// Define CAP_TEST_PATTERN_EN to replace camera pixels with colour bars.
module cmos_frame_capture #(
  parameter int H_PIXELS    = 1024,
  parameter int V_LINES     = 768,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_init_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        sys_we,
  output logic [15:0] sys_data_in,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        line_err,
  output logic [15:0] frame_cnt
);

  localparam int PW = $clog2(H_PIXELS + 2);
  localparam int LW = $clog2(V_LINES + 2);
  localparam int SW = $clog2(SKIP_FRAMES + 2);

  localparam logic [PW-1:0] H_N    = PW'(H_PIXELS);
  localparam logic [PW-1:0] H_SAT  = PW'(H_PIXELS + 1);
  localparam logic [LW-1:0] V_N    = LW'(V_LINES);
  localparam logic [LW-1:0] V_SAT  = LW'(V_LINES + 1);
  localparam logic [SW-1:0] SKIP_N = SW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_WAIT,
    S_CAP
  } state_t;

  state_t        state_q, state_d;
  logic          vs_r_q, vs_r_d;
  logic          hr_r_q, hr_r_d;
  logic [7:0]    d_r_q, d_r_d;
  logic          vs_p_q, vs_p_d;
  logic          hr_p_q, hr_p_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic          we_q, we_d;
  logic [15:0]   data_q, data_d;
  logic          fv_q, fv_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic          vs_rise, vs_fall;
  logic          hr_fall, byte_ok;
  logic [15:0]   pixel;

  assign vs_rise = vs_r_q & ~vs_p_q;
  assign vs_fall = ~vs_r_q & vs_p_q;
  // Line activity only counts outside vertical blanking.
  assign hr_fall = hr_p_q & ~hr_r_q & ~vs_r_q;
  assign byte_ok = hr_r_q & ~vs_r_q;

`ifdef CAP_TEST_PATTERN_EN
  logic [2:0] bar;

  always_comb begin
    bar = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (int'(pix_q) >= (b * H_PIXELS) / 8) begin
        bar = 3'(b);
      end
    end
    unique case (bar)
      3'd0: pixel = 16'hFFFF;
      3'd1: pixel = 16'hFFE0;
      3'd2: pixel = 16'h07FF;
      3'd3: pixel = 16'h07E0;
      3'd4: pixel = 16'hF81F;
      3'd5: pixel = 16'hF800;
      3'd6: pixel = 16'h001F;
      default: pixel = 16'h0000;
    endcase
  end
`else
  assign pixel = {hi_q, d_r_q};
`endif

  always_comb begin
    vs_r_d  = cmos_vsync;
    hr_r_d  = cmos_href;
    d_r_d   = cmos_data;
    vs_p_d  = vs_r_q;
    hr_p_d  = hr_r_q;
    state_d = state_q;
    skip_d  = skip_q;
    pix_d   = pix_q;
    line_d  = line_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    data_d  = data_q;
    fv_d    = fv_q;
    done_d  = 1'b0;
    err_d   = err_q;
    fcnt_d  = fcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (sdram_init_done) begin
          state_d = S_SKIP;
          skip_d  = '0;
        end
      end
      S_SKIP: begin
        if (skip_q == SKIP_N) begin
          state_d = S_WAIT;
        end else if (vs_rise) begin
          skip_d = skip_q + SW'(1);
        end
      end
      S_WAIT: begin
        if (vs_fall) begin
          state_d = S_CAP;
          pix_d   = '0;
          line_d  = '0;
          phase_d = 1'b0;
          err_d   = 1'b0;
          fv_d    = 1'b1;
        end
      end
      S_CAP: begin
        if (vs_rise) begin
          if (line_q != V_N) err_d = 1'b1;
          fv_d    = 1'b0;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
          phase_d = 1'b0;
          state_d = S_WAIT;
        end else if (hr_fall) begin
          if (pix_q != H_N) err_d = 1'b1;
          if (line_q != V_SAT) line_d = line_q + LW'(1);
          pix_d   = '0;
          phase_d = 1'b0;
        end else if (byte_ok) begin
          if (!phase_q) begin
            hi_d    = d_r_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pix_q < H_N && line_q < V_N) begin
              we_d   = 1'b1;
              data_d = pixel;
            end
            if (pix_q != H_SAT) pix_d = pix_q + PW'(1);
          end
        end
      end
    endcase

    // Losing the frame buffer aborts any capture in flight.
    if (!sdram_init_done) begin
      state_d = S_IDLE;
      fv_d    = 1'b0;
      we_d    = 1'b0;
      done_d  = 1'b0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vs_r_q  <= 1'b0;
      hr_r_q  <= 1'b0;
      d_r_q   <= '0;
      vs_p_q  <= 1'b0;
      hr_p_q  <= 1'b0;
      skip_q  <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_r_q  <= vs_r_d;
      hr_r_q  <= hr_r_d;
      d_r_q   <= d_r_d;
      vs_p_q  <= vs_p_d;
      hr_p_q  <= hr_p_d;
      skip_q  <= skip_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign sys_we      = we_q;
  assign sys_data_in = data_q;
  assign frame_valid = fv_q;
  assign frame_done  = done_q;
  assign line_err    = err_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Scoreboard bench for cmos_frame_capture: frame-level reference
// model queues expected pixels/frame ends, a monitor checks them.
module tb_cmos_frame_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        vs;
  logic        hr;
  logic [7:0]  dat;
  logic        sys_we;
  logic [15:0] sys_data_in;
  logic        frame_valid;
  logic        frame_done;
  logic        line_err;
  logic [15:0] frame_cnt;

  cmos_frame_capture #(
    .H_PIXELS    (H),
    .V_LINES     (V),
    .SKIP_FRAMES (SK)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (init),
    .cmos_vsync      (vs),
    .cmos_href       (hr),
    .cmos_data       (dat),
    .sys_we          (sys_we),
    .sys_data_in     (sys_data_in),
    .frame_valid     (frame_valid),
    .frame_done      (frame_done),
    .line_err        (line_err),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] pix;
  } px_t;

  typedef struct {
    logic        err;
    logic [15:0] cnt;
  } dn_t;

  px_t pxq[$];
  dn_t dq[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Frame-level model state
  int          rises;
  bit          cap;
  bit          ferr;
  int          lines;
  logic [15:0] mcnt;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pix_of(input logic [7:0] h,
                                         input logic [7:0] l,
                                         input int p);
`ifdef CAP_TEST_PATTERN_EN
    case ((p * 8) / H)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
`else
    return {h, l};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart();
    rises = 0;
    cap   = 1'b0;
    ferr  = 1'b0;
    lines = 0;
  endtask

  // One line of nb bytes; pixels whose second byte lands at
  // index > lim are not expected (used around a reset).
  task automatic do_line(input int nb, input bit fixed, input int lim);
    logic [7:0] hi;
    logic [7:0] b;
    logic [7:0] fb[4];
    px_t        e;
    fb = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    hi = 8'h00;
    for (int j = 0; j < nb; j++) begin
      step();
      b   = (fixed && j < 4) ? fb[j] : 8'($urandom);
      hr  = 1'b1;
      dat = b;
      if (j % 2 == 0) begin
        hi = b;
      end else if (cap && j / 2 < H && lines < V && j <= lim) begin
        e.cyc = cyc + 2;
        e.pix = pix_of(hi, b, j / 2);
        pxq.push_back(e);
      end
    end
  endtask

  task automatic line(input int nb, input bit fixed);
    do_line(nb, fixed, 1 << 30);
    step();
    hr  = 1'b0;
    dat = 8'h00;
    if (cap) begin
      ferr  = ferr | (nb / 2 != H);
      lines = lines + 1;
    end
    repeat (5) step();
    if (cap) chk("line_err", line_err, ferr);
  endtask

  task automatic end_frame();
    dn_t d;
    step();
    vs = 1'b1;
    rises++;
    if (cap) begin
      ferr  = ferr | (lines != V);
      mcnt  = mcnt + 16'd1;
      d.err = ferr;
      d.cnt = mcnt;
      dq.push_back(d);
      cap = 1'b0;
    end
    repeat (3) step();
    // Stray HREF activity inside vertical blanking
    for (int j = 0; j < 4; j++) begin
      hr  = 1'b1;
      dat = 8'($urandom);
      step();
    end
    hr = 1'b0;
    repeat (3) step();
    vs = 1'b0;
    if (init && rises >= SK) begin
      cap   = 1'b1;
      ferr  = 1'b0;
      lines = 0;
    end
    repeat (5) step();
    chk("frame_valid", frame_valid, cap);
    if (cap) chk("err_clear", line_err, 1'b0);
  endtask

  task automatic frame(input int nl, input int bmin, input int bmax);
    for (int l = 0; l < nl; l++) line($urandom_range(bmax, bmin), 1'b0);
    end_frame();
  endtask

  always @(negedge clk) begin
    if (sys_we === 1'b1) begin
      if (pxq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_we: got %h expected no write",
                 sys_data_in);
      end else begin
        px_t e;
        e = pxq.pop_front();
        chk("pix_data", sys_data_in, e.pix);
        chk("pix_time", cyc, e.cyc);
        chk("we_fv", frame_valid, 1'b1);
      end
    end
    if (frame_done === 1'b1) begin
      if (dq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got pulse expected none");
      end else begin
        dn_t d;
        d = dq.pop_front();
        chk("done_err", line_err, d.err);
        chk("done_cnt", frame_cnt, d.cnt);
        chk("done_fv", frame_valid, 1'b0);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    init = 1'b1;
    vs   = 1'b0;
    hr   = 1'b0;
    dat  = 8'h00;
    mcnt = 16'd0;
    model_restart();
    repeat (3) step();
    chk("rst_we", sys_we, 1'b0);
    chk("rst_data", sys_data_in, 16'h0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", line_err, 1'b0);
    chk("rst_cnt", frame_cnt, 16'h0);
    rst = 1'b0;
    repeat (4) step();

    // Four clean frames; the third carries the fixed byte pattern
    for (int f = 0; f < 4; f++) begin
      for (int l = 0; l < V; l++) line(2 * H, f == 2 && l == 0);
      end_frame();
    end
    chk("cnt_after_4", frame_cnt, 16'd2);

    // Long line, then a clean frame
    line(16, 1'b0);
    line(20, 1'b0);
    line(16, 1'b0);
    line(16, 1'b0);
    end_frame();
    frame(V, 16, 16);

    // Odd trailing byte
    line(16, 1'b0);
    line(17, 1'b0);
    line(16, 1'b0);
    line(16, 1'b0);
    end_frame();

    // Too many, then too few lines
    frame(V + 1, 16, 16);
    frame(V - 1, 16, 16);

    // Init dropped and re-raised inside a captured frame
    line(16, 1'b0);
    line(16, 1'b0);
    step();
    init = 1'b0;
    cap  = 1'b0;
    repeat (3) step();
    chk("init_fv", frame_valid, 1'b0);
    init = 1'b1;
    model_restart();
    line(16, 1'b0);
    line(16, 1'b0);
    end_frame();
    frame(V, 16, 16);
    frame(V, 16, 16);

    // Reset in the middle of a line of a captured frame
    line(16, 1'b0);
    do_line(9, 1'b0, 9 - 2);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_we", sys_we, 1'b0);
    chk("mid_rst_fv", frame_valid, 1'b0);
    chk("mid_rst_cnt", frame_cnt, 16'h0);
    rst  = 1'b0;
    hr   = 1'b0;
    mcnt = 16'd0;
    model_restart();
    repeat (6) step();
    line(16, 1'b0);
    line(16, 1'b0);
    end_frame();
    frame(V, 16, 16);
    frame(V, 16, 16);
    chk("cnt_after_rst", frame_cnt, 16'd1);

    // Randomised geometry
    for (int f = 0; f < 5; f++) begin
      frame($urandom_range(V + 1, V - 1), 14, 20);
    end

    repeat (20) step();
    chk("pix_queue_empty", pxq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_frame_capture.md
Name: cmos_frame_capture

Overview:
- Upstream feeder for the SDRAM/VGA frame-buffer top.
- Samples an 8-bit camera byte stream (VSYNC/HREF/DATA, OV7670-style, already in the `clk` domain) and pairs bytes into RGB565 pixels.
- Drives the frame buffer's `sys_we`/`sys_data_in`/`frame_valid` inputs.
- Gates capture on SDRAM init, skips warm-up frames, and aligns to frame boundaries.
- Clips oversize lines/frames and flags geometry errors.

Parameters:
- H_PIXELS, 1024, pixels per line written to the frame buffer
- V_LINES, 768, lines per frame written to the frame buffer
- SKIP_FRAMES, 10, complete camera frames discarded after init before first capture (0 allowed)

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- sdram_init_done  in  1  frame buffer ready; level
- cmos_vsync  in  1  camera VSYNC, high = vertical blanking
- cmos_href  in  1  camera HREF, high = active line bytes
- cmos_data  in  8  camera byte; first byte = pixel[15:8], second = pixel[7:0]
- sys_we  out  1  one-cycle pixel write strobe
- sys_data_in  out  16  RGB565 pixel, valid when sys_we=1
- frame_valid  out  1  high while a frame is being captured
- frame_done  out  1  one-cycle pulse at end of each captured frame
- line_err  out  1  sticky per frame: some line pixel count != H_PIXELS, or line count != V_LINES
- frame_cnt  out  16  captured-frame counter, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0; state=IDLE; counters 0; byte phase 0.
- Stage 1: vsync/href/data registered (`vs_r`, `hr_r`, `d_r`). `vs_rise`/`vs_fall` are detected against the previous `vs_r`.
- State IDLE: wait for `sdram_init_done`=1, then go to SKIP.
  - Deassertion of init in any state: return to IDLE next cycle, `frame_valid`=0, no further `sys_we`.
- State SKIP: count `vs_rise`. When count reaches SKIP_FRAMES (immediately if 0), go to WAIT_VS.
- State WAIT_VS: on `vs_fall`, go to CAPTURE.
  - Same cycle: clear pixel count, line count, and `line_err`; set `frame_valid`=1.
- State CAPTURE: while `hr_r`=1, bytes alternate phase 0/1.
  - Phase 0: latch high byte.
  - Phase 1: form pixel {hi, `d_r`}.
  - `sys_we`=1 and `sys_data_in`=pixel in the cycle after the phase-1 byte was sampled (2 cycles after the byte is on `cmos_data`).
  - Write only if pixel index < H_PIXELS and line index < V_LINES; otherwise drop silently (clip).
- `hr_r` falling edge (end of line):
  - Byte phase resets to 0; an odd trailing byte is discarded.
  - If pixel count != H_PIXELS, set `line_err`.
  - Line count increments, saturating at V_LINES+1. Pixel count clears.
- `vs_rise` in CAPTURE (end of frame):
  - If line count != V_LINES, set `line_err`.
  - `frame_valid`=0 next cycle; `frame_done` pulses 1 cycle; `frame_cnt`++.
  - Return to WAIT_VS.
- `line_err` holds until the next frame start.
- A frame already in progress when WAIT_VS is entered (VSYNC low) is never partially captured; the first write is always pixel (0,0).
- HREF high during VSYNC high is ignored.
- Reset mid-frame: outputs cleared the same edge; capture resumes via IDLE/SKIP.
- `sys_we` is never asserted while `frame_valid`=0.

Optional Feature:
- `CAP_TEST_PATTERN_EN` defined: pixel data is replaced by 8 vertical colour bars, each H_PIXELS/8 wide.
  - Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Indexed by pixel count; timing, strobes, and clipping are unchanged (still driven by camera sync).
- Undefined: camera bytes are used as-is.

Test Plan:
- SKIP_FRAMES=2, init high from reset, 4 clean frames (H_PIXELS=8, V_LINES=4) -> no `sys_we` during frames 1–2; frames 3–4 each yield exactly 32 strobes, `frame_done` x2, `frame_cnt`=2, `line_err`=0.
- Bytes 0xF8,0x1F,0x07,0xE0 on one line -> `sys_data_in`=F81F then 07E0, each strobe 2 cycles after its second byte.
- Line with 10 pixels (H_PIXELS=8) -> 8 strobes, `line_err`=1 after HREF falls; next frame clean -> `line_err` cleared at frame start.
- Line with odd byte count (17 bytes) -> 8 pixels written, trailing byte dropped, `line_err`=0.
- Init asserted mid-frame -> no writes until the following VSYNC fall; first `sys_data_in` equals that frame's first pixel.
- `rst` pulsed mid-line -> `sys_we`, `frame_valid`, `frame_cnt`=0 at next edge; SKIP repeats before capture resumes.
